rs_issue_stage: RTL and testbench

- Sits directly downstream of the reservation station pop ports and upstream of the functional units.
- Each lane takes one popped entry and holds it while snooping wakeup tags until all source operands are available.
- It then reads the physical register file and presents the entry plus operand values to the execution unit with a valid/ready handshake.
- Held entries are killed by speculative flush and have their branch masks aged.

---
 rtl/rs_issue_stage_pkg.sv | 12 +
 rtl/structs_pkg.sv | 17 +
 rtl/rs_issue_lane.sv | 119 +++++++++++
 rtl/rs_issue_stage.sv | 58 +++++
 tb/tb_rs_issue_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rs_issue_stage_pkg.sv
// Types and constants for the reservation-station issue stage.
package rs_issue_stage_pkg;
  typedef enum logic [1:0] {
    ISSUE_IDLE,
    ISSUE_WAIT,
    ISSUE_READ,
    ISSUE_DONE
  } issue_state_e;

  localparam int ISSUE_REGISTERS = 128;
  localparam int ISSUE_TAG_W     = $clog2(ISSUE_REGISTERS);
endpackage

// File: rtl/structs_pkg.sv
// Shared micro-op structures used across the out-of-order core.
package structs_pkg;
  localparam int PREG_TAG_W    = 7;
  localparam int BRANCH_MASK_W = 4;

  typedef struct packed {
    logic [7:0]               uop;
    logic [PREG_TAG_W-1:0]    rd;
    logic [PREG_TAG_W-1:0]    rs1;
    logic [PREG_TAG_W-1:0]    rs2;
    logic [PREG_TAG_W-1:0]    rs3;
    logic                     pending1;
    logic                     pending2;
    logic                     pending3;
    logic [BRANCH_MASK_W-1:0] branch_if;
  } reservation_entry2_t;
endpackage

// File: rtl/rs_issue_lane.sv
// One issue lane: holds an entry until its sources wake up, reads the RF for one
// cycle, then offers it to the functional unit. Two cycles minimum accept-to-valid.
module rs_issue_lane
  import structs_pkg::*;
  import rs_issue_stage_pkg::*;
#(
  parameter int SEARCH_PORTS     = 4,
  parameter int TAG_W            = ISSUE_TAG_W,
  parameter int DATA_WIDTH       = 32,
  parameter int EXTRA_DATA_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   valid_in,
  output logic                                   ready_out,
  input  reservation_entry2_t                    data_in,
  input  logic [EXTRA_DATA_WIDTH-1:0]            extra_in,
  output logic                                   valid_out,
  input  logic                                   ready_in,
  output reservation_entry2_t                    data_out,
  output logic [EXTRA_DATA_WIDTH-1:0]            extra_out,
  output logic [2:0][DATA_WIDTH-1:0]             op_out,
  output logic [2:0][TAG_W-1:0]                  rf_addr,
  input  logic [2:0][DATA_WIDTH-1:0]             rf_data,
  input  logic [SEARCH_PORTS-1:0]                search_valid,
  input  logic [SEARCH_PORTS-1:0][TAG_W-1:0]     search_tags,
  input  logic                                   branch_resolved,
  input  logic                                   flush
);
  issue_state_e                  state_q;
  reservation_entry2_t           entry_q;
  logic [EXTRA_DATA_WIDTH-1:0]   extra_q;
  logic [2:0][DATA_WIDTH-1:0]    op_q;

  reservation_entry2_t in_entry_d;
  reservation_entry2_t held_entry_d;
  logic [2:0]          in_hit;
  logic [2:0]          held_hit;
  logic                accept;
  logic                kill_held;

  always_comb begin
    in_hit   = '0;
    held_hit = '0;
    for (int k = 0; k < SEARCH_PORTS; k++) begin
      if (search_valid[k]) begin
        if (search_tags[k] == data_in.rs1) in_hit[0] = 1'b1;
        if (search_tags[k] == data_in.rs2) in_hit[1] = 1'b1;
        if (search_tags[k] == data_in.rs3) in_hit[2] = 1'b1;
        if (search_tags[k] == entry_q.rs1) held_hit[0] = 1'b1;
        if (search_tags[k] == entry_q.rs2) held_hit[1] = 1'b1;
        if (search_tags[k] == entry_q.rs3) held_hit[2] = 1'b1;
      end
    end
  end

  // Wakeup and branch-mask ageing applied to both the incoming and held entry.
  always_comb begin
    in_entry_d           = data_in;
    in_entry_d.pending1  = data_in.pending1 & ~in_hit[0];
    in_entry_d.pending2  = data_in.pending2 & ~in_hit[1];
    in_entry_d.pending3  = data_in.pending3 & ~in_hit[2];
    if (branch_resolved) in_entry_d.branch_if = data_in.branch_if >> 1;

    held_entry_d          = entry_q;
    held_entry_d.pending1 = entry_q.pending1 & ~held_hit[0];
    held_entry_d.pending2 = entry_q.pending2 & ~held_hit[1];
    held_entry_d.pending3 = entry_q.pending3 & ~held_hit[2];
    if (branch_resolved) held_entry_d.branch_if = entry_q.branch_if >> 1;
  end

  assign ready_out = (state_q == ISSUE_IDLE) | ((state_q == ISSUE_DONE) & ready_in);
  assign accept    = valid_in & ready_out;
  assign kill_held = flush & (|entry_q.branch_if);
  assign valid_out = (state_q == ISSUE_DONE) & ~kill_held;
  assign data_out  = entry_q;
  assign extra_out = extra_q;
  assign op_out    = op_q;
  assign rf_addr   = (state_q == ISSUE_READ) ? {entry_q.rs3, entry_q.rs2, entry_q.rs1} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE_IDLE;
      entry_q <= '0;
      extra_q <= '0;
      op_q    <= '0;
    end else if (accept) begin
      // A speculative entry arriving during a flush is handshaken but dropped.
      if (flush && (|data_in.branch_if)) begin
        state_q <= ISSUE_IDLE;
      end else begin
        entry_q <= in_entry_d;
        extra_q <= extra_in;
        state_q <= (in_entry_d.pending1 | in_entry_d.pending2 | in_entry_d.pending3)
                   ? ISSUE_WAIT : ISSUE_READ;
      end
    end else if ((state_q != ISSUE_IDLE) && kill_held) begin
      state_q <= ISSUE_IDLE;
    end else begin
      case (state_q)
        ISSUE_WAIT: begin
          entry_q <= held_entry_d;
          if (!(held_entry_d.pending1 | held_entry_d.pending2 | held_entry_d.pending3))
            state_q <= ISSUE_READ;
        end
        ISSUE_READ: begin
          entry_q <= held_entry_d;
          op_q    <= rf_data;
          state_q <= ISSUE_DONE;
        end
        ISSUE_DONE: begin
          entry_q <= held_entry_d;
          if (ready_in) state_q <= ISSUE_IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rs_issue_stage.sv
// Issue stage between the reservation station pop ports and the functional units;
// one independent rs_issue_lane per pop port.
module rs_issue_stage
  import structs_pkg::*;
  import rs_issue_stage_pkg::*;
#(
  parameter int LANES            = 2,
  parameter int SEARCH_PORTS     = 4,
  parameter int REGISTERS        = ISSUE_REGISTERS,
  parameter int DATA_WIDTH       = 32,
  parameter int EXTRA_DATA_WIDTH = 4,
  localparam int TAG_W           = $clog2(REGISTERS)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [LANES-1:0]                            valid_in,
  output logic [LANES-1:0]                            ready_out,
  input  reservation_entry2_t [LANES-1:0]             data_in,
  input  logic [LANES-1:0][EXTRA_DATA_WIDTH-1:0]      extra_in,
  output logic [LANES-1:0]                            valid_out,
  input  logic [LANES-1:0]                            ready_in,
  output reservation_entry2_t [LANES-1:0]             data_out,
  output logic [LANES-1:0][EXTRA_DATA_WIDTH-1:0]      extra_out,
  output logic [LANES-1:0][2:0][DATA_WIDTH-1:0]       op_out,
  output logic [LANES-1:0][2:0][TAG_W-1:0]            rf_addr,
  input  logic [LANES-1:0][2:0][DATA_WIDTH-1:0]       rf_data,
  input  logic [SEARCH_PORTS-1:0]                     search_valid,
  input  logic [SEARCH_PORTS-1:0][TAG_W-1:0]          search_tags,
  input  logic                                        branch_resolved,
  input  logic                                        flush
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rs_issue_lane #(
      .SEARCH_PORTS     (SEARCH_PORTS),
      .TAG_W            (TAG_W),
      .DATA_WIDTH       (DATA_WIDTH),
      .EXTRA_DATA_WIDTH (EXTRA_DATA_WIDTH)
    ) u_lane (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in[g]),
      .ready_out       (ready_out[g]),
      .data_in         (data_in[g]),
      .extra_in        (extra_in[g]),
      .valid_out       (valid_out[g]),
      .ready_in        (ready_in[g]),
      .data_out        (data_out[g]),
      .extra_out       (extra_out[g]),
      .op_out          (op_out[g]),
      .rf_addr         (rf_addr[g]),
      .rf_data         (rf_data[g]),
      .search_valid    (search_valid),
      .search_tags     (search_tags),
      .branch_resolved (branch_resolved),
      .flush           (flush)
    );
  end
endmodule

// File: tb/tb_rs_issue_stage.sv
// Directed bench for rs_issue_stage: inputs driven on the falling edge, outputs checked 1ns later.
module tb_rs_issue_stage;
  import structs_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [1:0]               valid_in, ready_out, valid_out, ready_in;
  reservation_entry2_t [1:0] data_in, data_out;
  logic [1:0][3:0]          extra_in, extra_out;
  logic [1:0][2:0][31:0]    op_out, rf_data;
  logic [1:0][2:0][6:0]     rf_addr;
  logic [3:0]               search_valid;
  logic [3:0][6:0]          search_tags;
  logic                     branch_resolved, flush;
  logic [31:0]              rf_mem [128];

  int tests = 0;
  int fails = 0;

  rs_issue_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
    .extra_in(extra_in), .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
    .extra_out(extra_out), .op_out(op_out), .rf_addr(rf_addr), .rf_data(rf_data),
    .search_valid(search_valid), .search_tags(search_tags),
    .branch_resolved(branch_resolved), .flush(flush)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    for (int l = 0; l < 2; l++)
      for (int j = 0; j < 3; j++)
        rf_data[l][j] = rf_mem[rf_addr[l][j]];
  end

  function automatic reservation_entry2_t mk(input logic [6:0] r1, input logic [6:0] r2,
                                             input logic [6:0] r3, input logic [2:0] p,
                                             input logic [3:0] b);
    reservation_entry2_t e;
    e           = '0;
    e.uop       = 8'h3C;
    e.rd        = 7'd99;
    e.rs1       = r1;
    e.rs2       = r2;
    e.rs3       = r3;
    e.pending1  = p[0];
    e.pending2  = p[1];
    e.pending3  = p[2];
    e.branch_if = b;
    return e;
  endfunction

  task automatic idle_inputs();
    valid_in = '0; ready_in = '0; data_in = '0; extra_in = '0;
    search_valid = '0; search_tags = '0; branch_resolved = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain();
    idle_inputs();
    ready_in = 2'b11;
    repeat (3) step();
    ready_in = 2'b00;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    tests++; if (valid_out !== 2'b00) begin fails++; $display("FAIL reset_valid got %b want 00", valid_out); end
    tests++; if (ready_out !== 2'b11) begin fails++; $display("FAIL reset_ready got %b want 11", ready_out); end
    tests++; if (data_out !== '0) begin fails++; $display("FAIL reset_data got %h want 0", data_out); end
    tests++; if (op_out !== '0) begin fails++; $display("FAIL reset_op got %h want 0", op_out); end
    tests++; if (rf_addr !== '0 || extra_out !== '0) begin fails++; $display("FAIL reset_addr_extra got %h/%h want 0", rf_addr, extra_out); end
  endtask

  task automatic test_no_pending();
    reservation_entry2_t e;
    e = mk(7'd5, 7'd9, 7'd0, 3'b000, 4'b0000);
    step(); valid_in = 2'b01; data_in[0] = e; extra_in[0] = 4'h5; #1;
    tests++; if (ready_out[0] !== 1'b1) begin fails++; $display("FAIL np_accept_ready got %b want 1", ready_out[0]); end
    step(); idle_inputs(); #1;
    tests++; if (ready_out[0] !== 1'b0 || valid_out[0] !== 1'b0) begin fails++; $display("FAIL np_read_state got rdy=%b vld=%b want 0/0", ready_out[0], valid_out[0]); end
    tests++; if (rf_addr[0][0] !== 7'd5 || rf_addr[0][1] !== 7'd9) begin fails++; $display("FAIL np_rf_addr got %0d/%0d want 5/9", rf_addr[0][0], rf_addr[0][1]); end
    step(); #1;
    tests++; if (valid_out[0] !== 1'b1 || ready_out[0] !== 1'b0) begin fails++; $display("FAIL np_valid got vld=%b rdy=%b want 1/0", valid_out[0], ready_out[0]); end
    tests++; if (op_out[0][0] !== 32'hA || op_out[0][1] !== 32'hB || op_out[0][2] !== 32'h1000) begin fails++; $display("FAIL np_ops got %h %h %h want a b 1000", op_out[0][0], op_out[0][1], op_out[0][2]); end
    tests++; if (data_out[0] !== e || extra_out[0] !== 4'h5) begin fails++; $display("FAIL np_data got %h/%h want %h/5", data_out[0], extra_out[0], e); end
    tests++; if (rf_addr[0] !== '0) begin fails++; $display("FAIL np_addr_done got %h want 0", rf_addr[0]); end
    step(); #1;
    tests++; if (valid_out[0] !== 1'b1) begin fails++; $display("FAIL np_hold got %b want 1", valid_out[0]); end
    ready_in = 2'b01; #1;
    tests++; if (ready_out[0] !== 1'b1) begin fails++; $display("FAIL np_ready_on_consume got %b want 1", ready_out[0]); end
    step(); ready_in = 2'b00; #1;
    tests++; if (valid_out[0] !== 1'b0 || ready_out[0] !== 1'b1) begin fails++; $display("FAIL np_idle got vld=%b rdy=%b want 0/1", valid_out[0], ready_out[0]); end
  endtask

  task automatic test_wakeup_wait();
    step(); valid_in = 2'b01; data_in[0] = mk(7'd20, 7'd1, 7'd2, 3'b001, 4'b0000);
    step(); idle_inputs(); search_tags[0] = 7'd20; #1;
    tests++; if (rf_addr[0][0] !== 7'd0 || ready_out[0] !== 1'b0) begin fails++; $display("FAIL ww_c1 got addr=%0d rdy=%b want 0/0", rf_addr[0][0], ready_out[0]); end
    step(); idle_inputs(); search_valid = 4'b0001; search_tags[0] = 7'd21; #1;
    tests++; if (rf_addr[0][0] !== 7'd0) begin fails++; $display("FAIL ww_c2 got addr=%0d want 0", rf_addr[0][0]); end
    step(); idle_inputs(); #1;
    tests++; if (rf_addr[0][0] !== 7'd0 || valid_out[0] !== 1'b0) begin fails++; $display("FAIL ww_c3 got addr=%0d vld=%b want 0/0", rf_addr[0][0], valid_out[0]); end
    step(); search_valid = 4'b0100; search_tags[2] = 7'd20; #1;
    tests++; if (rf_addr[0][0] !== 7'd0) begin fails++; $display("FAIL ww_c4 got addr=%0d want 0", rf_addr[0][0]); end
    step(); idle_inputs(); #1;
    tests++; if (rf_addr[0][0] !== 7'd20 || valid_out[0] !== 1'b0) begin fails++; $display("FAIL ww_c5_read got addr=%0d vld=%b want 20/0", rf_addr[0][0], valid_out[0]); end
    step(); #1;
    tests++; if (valid_out[0] !== 1'b1 || op_out[0][0] !== 32'h1014) begin fails++; $display("FAIL ww_c6_valid got vld=%b op=%h want 1/1014", valid_out[0], op_out[0][0]); end
    tests++; if (data_out[0].pending1 !== 1'b0) begin fails++; $display("FAIL ww_pending got %b want 0", data_out[0].pending1); end
    drain();
  endtask

  task automatic test_same_cycle_wakeup();
    step(); valid_in = 2'b01; data_in[0] = mk(7'd3, 7'd33, 7'd4, 3'b010, 4'b0000);
    search_valid = 4'b1000; search_tags[3] = 7'd33;
    step(); idle_inputs(); #1;
    tests++; if (rf_addr[0][1] !== 7'd33) begin fails++; $display("FAIL sc_read got addr=%0d want 33", rf_addr[0][1]); end
    step(); #1;
    tests++; if (valid_out[0] !== 1'b1 || op_out[0][1] !== 32'h1021) begin fails++; $display("FAIL sc_valid got vld=%b op=%h want 1/1021", valid_out[0], op_out[0][1]); end
    drain();
  endtask

  task automatic test_back_to_back();
    reservation_entry2_t a, b;
    int consumed_a;
    a = mk(7'd10, 7'd11, 7'd12, 3'b000, 4'b0000);
    b = mk(7'd13, 7'd14, 7'd15, 3'b000, 4'b0000);
    consumed_a = 0;
    step(); valid_in = 2'b10; data_in[1] = a;
    step(); idle_inputs();
    step(); valid_in = 2'b10; ready_in = 2'b10; data_in[1] = b; #1;
    tests++; if (valid_out[1] !== 1'b1 || data_out[1] !== a) begin fails++; $display("FAIL b2b_a_valid got vld=%b dat=%h want 1/%h", valid_out[1], data_out[1], a); end
    tests++; if (ready_out[1] !== 1'b1) begin fails++; $display("FAIL b2b_refill_ready got %b want 1", ready_out[1]); end
    if (valid_out[1] && data_out[1] === a) consumed_a++;
    step(); valid_in = 2'b00; #1;
    if (valid_out[1] && data_out[1] === a) consumed_a++;
    tests++; if (valid_out[1] !== 1'b0 || rf_addr[1][0] !== 7'd13) begin fails++; $display("FAIL b2b_b_read got vld=%b addr=%0d want 0/13", valid_out[1], rf_addr[1][0]); end
    step(); #1;
    tests++; if (valid_out[1] !== 1'b1 || data_out[1] !== b || op_out[1][2] !== 32'h100F) begin fails++; $display("FAIL b2b_b_valid got vld=%b op=%h want 1/100f", valid_out[1], op_out[1][2]); end
    step(); ready_in = 2'b00; #1;
    tests++; if (valid_out[1] !== 1'b0) begin fails++; $display("FAIL b2b_b_once got %b want 0", valid_out[1]); end
    tests++; if (consumed_a != 1) begin fails++; $display("FAIL b2b_a_once got %0d want 1", consumed_a); end
  endtask

  task automatic test_branch();
    // Speculative entry waiting in lane 0, non-speculative entry in lane 1.
    step(); valid_in = 2'b11;
    data_in[0] = mk(7'd40, 7'd41, 7'd42, 3'b001, 4'b0010);
    data_in[1] = mk(7'd6, 7'd7, 7'd8, 3'b000, 4'b0000);
    step(); idle_inputs(); branch_resolved = 1'b1; #1;
    tests++; if (data_out[0].branch_if !== 4'b0010) begin fails++; $display("FAIL br_pre_shift got %b want 0010", data_out[0].branch_if); end
    step(); branch_resolved = 1'b0; #1;
    tests++; if (data_out[0].branch_if !== 4'b0001) begin fails++; $display("FAIL br_shift got %b want 0001", data_out[0].branch_if); end
    flush = 1'b1; ready_in = 2'b10; #1;
    tests++; if (valid_out !== 2'b10) begin fails++; $display("FAIL br_flush_valid got %b want 10", valid_out); end
    step(); idle_inputs(); search_valid = 4'b0001; search_tags[0] = 7'd40; #1;
    tests++; if (ready_out[0] !== 1'b1 || valid_out[1] !== 1'b0) begin fails++; $display("FAIL br_killed got rdy0=%b vld1=%b want 1/0", ready_out[0], valid_out[1]); end
    step(); idle_inputs(); #1;
    tests++; if (rf_addr[0][0] !== 7'd0 || valid_out[0] !== 1'b0) begin fails++; $display("FAIL br_no_read got addr=%0d vld=%b want 0/0", rf_addr[0][0], valid_out[0]); end
    step(); #1;
    tests++; if (valid_out[0] !== 1'b0) begin fails++; $display("FAIL br_never_valid got %b want 0", valid_out[0]); end
    // Speculative entry killed while already presenting valid_out.
    step(); valid_in = 2'b01; data_in[0] = mk(7'd1, 7'd2, 7'd3, 3'b000, 4'b0001);
    step(); idle_inputs();
    step(); #1;
    tests++; if (valid_out[0] !== 1'b1) begin fails++; $display("FAIL br_done_valid got %b want 1", valid_out[0]); end
    flush = 1'b1; #1;
    tests++; if (valid_out[0] !== 1'b0) begin fails++; $display("FAIL br_done_masked got %b want 0", valid_out[0]); end
    step(); flush = 1'b0; #1;
    tests++; if (valid_out[0] !== 1'b0 || ready_out[0] !== 1'b1) begin fails++; $display("FAIL br_done_killed got vld=%b rdy=%b want 0/1", valid_out[0], ready_out[0]); end
    // Speculative entry arriving during a flush is dropped.
    step(); valid_in = 2'b01; flush = 1'b1; data_in[0] = mk(7'd1, 7'd2, 7'd3, 3'b000, 4'b0100); #1;
    tests++; if (ready_out[0] !== 1'b1) begin fails++; $display("FAIL br_in_ready got %b want 1", ready_out[0]); end
    step(); idle_inputs(); #1;
    tests++; if (ready_out[0] !== 1'b1 || rf_addr[0][0] !== 7'd0) begin fails++; $display("FAIL br_in_drop got rdy=%b addr=%0d want 1/0", ready_out[0], rf_addr[0][0]); end
    // Accept with branch_resolved stores the shifted mask; flush+resolve kills on pre-shift mask.
    step(); valid_in = 2'b01; branch_resolved = 1'b1; data_in[0] = mk(7'd1, 7'd2, 7'd50, 3'b100, 4'b1000);
    step(); idle_inputs(); #1;
    tests++; if (data_out[0].branch_if !== 4'b0100) begin fails++; $display("FAIL br_accept_shift got %b want 0100", data_out[0].branch_if); end
    flush = 1'b1; branch_resolved = 1'b1;
    step(); idle_inputs(); #1;
    tests++; if (ready_out[0] !== 1'b1) begin fails++; $display("FAIL br_flush_resolve got %b want 1", ready_out[0]); end
    drain();
  endtask

  task automatic test_async_reset();
    step(); valid_in = 2'b01; data_in[0] = mk(7'd5, 7'd9, 7'd0, 3'b000, 4'b0000);
    step(); valid_in = 2'b10; data_in[0] = '0; data_in[1] = mk(7'd20, 7'd33, 7'd0, 3'b000, 4'b0000);
    step(); idle_inputs(); #1;
    tests++; if (valid_out !== 2'b01 || rf_addr[1][0] !== 7'd20) begin fails++; $display("FAIL ar_pre got vld=%b addr=%0d want 01/20", valid_out, rf_addr[1][0]); end
    rst = 1'b1; #1;
    tests++; if (valid_out !== 2'b00 || ready_out !== 2'b11) begin fails++; $display("FAIL ar_immediate got vld=%b rdy=%b want 00/11", valid_out, ready_out); end
    tests++; if (rf_addr !== '0 || op_out !== '0) begin fails++; $display("FAIL ar_clear got addr=%h op=%h want 0", rf_addr, op_out); end
    step(); rst = 1'b0;
    step(); valid_in = 2'b01; data_in[0] = mk(7'd5, 7'd9, 7'd0, 3'b000, 4'b0000); #1;
    tests++; if (ready_out[0] !== 1'b1) begin fails++; $display("FAIL ar_accept got %b want 1", ready_out[0]); end
    step(); idle_inputs(); #1;
    tests++; if (rf_addr[0][0] !== 7'd5 || valid_out[0] !== 1'b0) begin fails++; $display("FAIL ar_read got addr=%0d vld=%b want 5/0", rf_addr[0][0], valid_out[0]); end
    step(); #1;
    tests++; if (valid_out !== 2'b01 || op_out[0][0] !== 32'hA) begin fails++; $display("FAIL ar_valid got vld=%b op=%h want 01/a", valid_out, op_out[0][0]); end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[5] = 32'hA;
    rf_mem[9] = 32'hB;
    idle_inputs();
    test_reset();
    test_no_pending();
    test_wakeup_wait();
    test_same_cycle_wakeup();
    test_back_to_back();
    test_branch();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
